// File: rtl/scan_chain_master.sv
// scan_chain_master: host-side driver for the two-phase (phi/phib) scan chain on the CNN die
// Ports: clk, rst_n (async active-low); start/rd_mode/wr_vec request an operation (write = shift-in + load,
// read = capture + shift-out); rd_vec collects scan_out; busy/done report progress; phi, phib, scan_i0o1,
// load, scan_in drive the chip and scan_out returns from it. Parameters: CHAIN_LEN cells, PHASE_CYCLES per phase.
// Macro SCAN_CHAIN_MASTER_ECHO_EN: writes also capture the chain's previous contents into rd_vec.
module scan_chain_master #(
  parameter int CHAIN_LEN = 256,
  parameter int PHASE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 rd_mode,
  input  logic [CHAIN_LEN-1:0] wr_vec,
  output logic [CHAIN_LEN-1:0] rd_vec,
  output logic                 busy,
  output logic                 done,
  output logic                 phi,
  output logic                 phib,
  output logic                 scan_i0o1,
  output logic                 load,
  output logic                 scan_in,
  input  logic                 scan_out
);
  localparam int PW = PHASE_CYCLES > 1 ? $clog2(PHASE_CYCLES) : 1;
  localparam int BW = CHAIN_LEN > 1 ? $clog2(CHAIN_LEN) : 1;
  typedef enum logic [3:0] {
    IDLE, CAP_SETUP, CAP_PHI, CAP_GAP, CAP_PHIB, SETUP, PHI, GAP, PHIB, LOAD, LOAD_GAP, DONE
  } state_t;
  state_t state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic mode_q, mode_n, last, bit_st, sample;
  logic [CHAIN_LEN-1:0] vec_q, vec_n;
  assign last = pcnt == PW'(PHASE_CYCLES - 1);
  // State encoding is ordered so every timed state simply steps to state+1 at the end of its phase.
  always_comb begin
    state_n = state;
    pcnt_n = last ? '0 : pcnt + 1'b1;
    bcnt_n = bcnt;
    mode_n = mode_q;
    vec_n = vec_q;
    case (state)
      IDLE: begin
        pcnt_n = '0;
        if (start) begin
          state_n = rd_mode ? CAP_SETUP : SETUP;
          bcnt_n = BW'(CHAIN_LEN - 1);
          mode_n = rd_mode;
          vec_n = wr_vec;
        end
      end
      PHIB: if (last) begin
        state_n = bcnt != '0 ? SETUP : mode_q ? DONE : LOAD;
        bcnt_n = bcnt != '0 ? bcnt - 1'b1 : bcnt;
      end
      DONE: begin
        state_n = IDLE;
        pcnt_n = '0;
      end
      default: if (last) state_n = state_t'(state + 4'd1);
    endcase
  end
  assign bit_st = state_n inside {SETUP, PHI, GAP, PHIB};
`ifdef SCAN_CHAIN_MASTER_ECHO_EN
  assign sample = state == SETUP && last;
`else
  assign sample = state == SETUP && last && mode_q;
`endif
  // Outputs are registered from the next state so each pin is aligned with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pcnt <= '0;
      bcnt <= '0;
      mode_q <= 1'b0;
      vec_q <= '0;
      rd_vec <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      phi <= 1'b0;
      phib <= 1'b0;
      scan_i0o1 <= 1'b0;
      load <= 1'b0;
      scan_in <= 1'b0;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
      bcnt <= bcnt_n;
      mode_q <= mode_n;
      vec_q <= vec_n;
      busy <= state_n != IDLE && state_n != DONE;
      done <= state_n == DONE;
      phi <= state_n inside {CAP_PHI, PHI};
      phib <= state_n inside {CAP_PHIB, PHIB};
      scan_i0o1 <= state_n inside {CAP_SETUP, CAP_PHI, CAP_GAP, CAP_PHIB};
      load <= state_n == LOAD;
      scan_in <= bit_st && !mode_n && vec_n[bcnt_n];
      if (sample) rd_vec[bcnt] <= scan_out;
    end
  end
endmodule

// File: tb/tb_scan_chain_master.sv
// tb_scan_chain_master: directed table-driven bench with a two-phase scan chain chip model
module tb_scan_chain_master;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic st[2] = '{1'b0, 1'b0};
  logic rdm[2] = '{1'b0, 1'b0};
  logic [N-1:0] wv[2] = '{8'h00, 8'h00};
  logic [N-1:0] rv[2];
  logic bsy[2], dn[2], phi[2], phib[2], sio[2], ld[2], si[2], so[2];
  scan_chain_master #(.CHAIN_LEN(N), .PHASE_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .rd_mode(rdm[0]), .wr_vec(wv[0]), .rd_vec(rv[0]),
    .busy(bsy[0]), .done(dn[0]), .phi(phi[0]), .phib(phib[0]), .scan_i0o1(sio[0]), .load(ld[0]),
    .scan_in(si[0]), .scan_out(so[0]));
  scan_chain_master #(.CHAIN_LEN(N), .PHASE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .rd_mode(rdm[1]), .wr_vec(wv[1]), .rd_vec(rv[1]),
    .busy(bsy[1]), .done(dn[1]), .phi(phi[1]), .phib(phib[1]), .scan_i0o1(sio[1]), .load(ld[1]),
    .scan_in(si[1]), .scan_out(so[1]));
  logic [N-1:0] chain[2] = '{8'h00, 8'h00};
  logic [N-1:0] mst[2] = '{8'h00, 8'h00};
  logic [N-1:0] cfg[2] = '{8'h00, 8'h00};
  logic [N-1:0] cap_val[2] = '{8'h00, 8'h00};
  logic use_cfg[2] = '{1'b0, 1'b1};
  logic phi_q[2] = '{1'b0, 1'b0};
  logic phib_q[2] = '{1'b0, 1'b0};
  logic ld_q[2] = '{1'b0, 1'b0};
  assign so[0] = chain[0][N-1];
  assign so[1] = chain[1][N-1];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      phi_q[i] <= phi[i];
      phib_q[i] <= phib[i];
      ld_q[i] <= ld[i];
      if (phi[i] && !phi_q[i]) mst[i] <= sio[i] ? (use_cfg[i] ? cfg[i] : cap_val[i]) : {chain[i][N-2:0], si[i]};
      if (phib[i] && !phib_q[i]) chain[i] <= mst[i];
      if (ld[i] && !ld_q[i]) cfg[i] <= chain[i];
    end
  end
  int cyc[2] = '{0, 0};
  int phi_r[2] = '{0, 0};
  int ld_hi[2] = '{0, 0};
  int sio_hi[2] = '{0, 0};
  int ovl[2] = '{0, 0};
  int dn_cnt[2] = '{0, 0};
  int min_gap[2] = '{1000, 1000};
  int lpf[2] = '{-1000, -1000};
  int lpbf[2] = '{-1000, -1000};
  logic phi_p[2] = '{1'b0, 1'b0};
  logic phib_p[2] = '{1'b0, 1'b0};
  logic [N-1:0] si_log[2] = '{8'h00, 8'h00};
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cyc[i] <= cyc[i] + 1;
      phi_p[i] <= phi[i];
      phib_p[i] <= phib[i];
      if (phi[i] && !phi_p[i]) begin
        phi_r[i] <= phi_r[i] + 1;
        si_log[i] <= {si_log[i][N-2:0], si[i]};
        if (cyc[i] - lpbf[i] < min_gap[i]) min_gap[i] <= cyc[i] - lpbf[i];
      end
      if (phib[i] && !phib_p[i] && cyc[i] - lpf[i] < min_gap[i]) min_gap[i] <= cyc[i] - lpf[i];
      if (!phi[i] && phi_p[i]) lpf[i] <= cyc[i];
      if (!phib[i] && phib_p[i]) lpbf[i] <= cyc[i];
      if (ld[i]) ld_hi[i] <= ld_hi[i] + 1;
      if (sio[i]) sio_hi[i] <= sio_hi[i] + 1;
      if (phi[i] && phib[i]) ovl[i] <= ovl[i] + 1;
      if (dn[i]) dn_cnt[i] <= dn_cnt[i] + 1;
    end
  end
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_op(input int i, input logic rd, input logic [N-1:0] v, output int lat);
    @(negedge clk);
    rdm[i] = rd;
    wv[i] = v;
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    lat = 0;
    while (!dn[i] && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
  endtask
  typedef struct {
    logic rd;
    logic [N-1:0] vec;
    logic [N-1:0] cap;
    logic [N-1:0] rv;
    logic [N-1:0] cfg;
    int lat;
    int phis;
    int ldc;
    int sioc;
  } op_t;
  op_t ops[5];
  initial begin
    int lat, p0, l0, s0, d0;
    logic [N-1:0] e2, e3;
`ifdef SCAN_CHAIN_MASTER_ECHO_EN
    e2 = 8'h00;
    e3 = 8'h5A;
`else
    e2 = 8'h3C;
    e3 = 8'h3C;
`endif
    ops[0] = '{1'b0, 8'hA5, 8'h00, 8'h00, 8'hA5, 68, 8, 2, 0};
    ops[1] = '{1'b1, 8'h00, 8'h3C, 8'h3C, 8'hA5, 72, 9, 0, 8};
    ops[2] = '{1'b0, 8'h5A, 8'h00, e2, 8'h5A, 68, 8, 2, 0};
    ops[3] = '{1'b0, 8'hC3, 8'h00, e3, 8'hC3, 68, 8, 2, 0};
    ops[4] = '{1'b1, 8'h00, 8'h81, 8'h81, 8'hC3, 72, 9, 0, 8};
    repeat (3) @(negedge clk);
    chk("reset_outs", {phi[0], phib[0], sio[0], ld[0], si[0], bsy[0], dn[0], phi[1], phib[1], bsy[1], dn[1]}, 0);
    chk("reset_rd_vec", {rv[0], rv[1]}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      p0 = phi_r[0];
      l0 = ld_hi[0];
      s0 = sio_hi[0];
      cap_val[0] = ops[k].cap;
      run_op(0, ops[k].rd, ops[k].vec, lat);
      chk($sformatf("op%0d_latency", k), lat, ops[k].lat);
      chk($sformatf("op%0d_busy_at_done", k), bsy[0], 0);
      chk($sformatf("op%0d_rd_vec", k), rv[0], ops[k].rv);
      chk($sformatf("op%0d_chip_cfg", k), cfg[0], ops[k].cfg);
      chk($sformatf("op%0d_phi_pulses", k), phi_r[0] - p0, ops[k].phis);
      chk($sformatf("op%0d_load_cycles", k), ld_hi[0] - l0, ops[k].ldc);
      chk($sformatf("op%0d_i0o1_cycles", k), sio_hi[0] - s0, ops[k].sioc);
      if (!ops[k].rd) chk($sformatf("op%0d_scan_in_bits", k), si_log[0], ops[k].vec);
      @(negedge clk);
      chk($sformatf("op%0d_done_pulse", k), dn[0], 0);
    end
    run_op(0, 1'b0, 8'h11, lat);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_in_done_ignored", {bsy[0], cfg[0]}, {1'b0, 8'h11});
    d0 = dn_cnt[0];
    p0 = phi_r[0];
    @(negedge clk);
    rdm[0] = 1'b0;
    wv[0] = 8'hA5;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (10) @(negedge clk);
    wv[0] = 8'hFF;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    lat = 0;
    while (!dn[0] && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    repeat (150) @(negedge clk);
    chk("busy_start_one_done", dn_cnt[0] - d0, 1);
    chk("busy_start_phi_pulses", phi_r[0] - p0, 8);
    chk("busy_start_cfg", cfg[0], 8'hA5);
    @(negedge clk);
    rdm[0] = 1'b0;
    wv[0] = 8'hFF;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (27) @(negedge clk);
    chk("pre_reset_phi_si", {phi[0], si[0], bsy[0]}, 3'b111);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", {phi[0], phib[0], ld[0], si[0], bsy[0], dn[0], sio[0], rv[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 8'h0F, lat);
    chk("post_reset_latency", lat, 68);
    chk("post_reset_cfg", cfg[0], 8'h0F);
    run_op(1, 1'b0, 8'h96, lat);
    chk("t1_write_latency", lat, 34);
    chk("t1_write_cfg", cfg[1], 8'h96);
    run_op(1, 1'b1, 8'h00, lat);
    chk("t1_read_latency", lat, 36);
    chk("t1_loopback_rd_vec", rv[1], 8'h96);
    chk("no_overlap", {ovl[0], ovl[1]}, 0);
    chk("t2_min_gap", min_gap[0] >= 2, 1);
    chk("t1_min_gap", min_gap[1] >= 1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
